// File: rtl/t03_vga_timing_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : t03_vga_timing_if                                          |
// | Description : Display-path bundle between the raster timing generator    |
// |               and the colour-mux stage.                                  |
// |   pixel_en    pixel tick (into the generator)                            |
// |   color_in    8-bit colour for the current Hcnt/Vcnt (into the generator)|
// |   Hcnt/Vcnt   11-bit raster position, stage-0 view                       |
// |   line_start  Hcnt==0 decode; frame_start  Hcnt==0 && Vcnt==0 decode     |
// |   hsync/vsync sync pulses, aligned with rgb_out                          |
// |   active      rgb_out carries a visible pixel                            |
// |   rgb_out     registered 8-bit colour to the pins                        |
// |   modport master : timing generator side                                 |
// |   modport slave  : consumer / pixel-source side                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface t03_vga_timing_if;
  logic        pixel_en;
  logic [7:0]  color_in;
  logic [10:0] Hcnt;
  logic [10:0] Vcnt;
  logic        line_start;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic [7:0]  rgb_out;

  modport master (
    input  pixel_en, color_in,
    output Hcnt, Vcnt, line_start, frame_start, hsync, vsync, active, rgb_out
  );

  modport slave (
    output pixel_en, color_in,
    input  Hcnt, Vcnt, line_start, frame_start, hsync, vsync, active, rgb_out
  );
endinterface
`default_nettype wire

// File: rtl/t03_vga_timing.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : t03_vga_timing                                             |
// | Description : SVGA raster timing generator and registered pixel output   |
// |               stage. Counts Hcnt/Vcnt, tracks horizontal and vertical    |
// |               phase (ACTIVE/FRONT/SYNC/BACK), and registers colour plus  |
// |               sync so all pin-side outputs describe the same pixel.      |
// | Ports       : clk   in  clock (pixel clock when pixel_en tied high)      |
// |               nrst  in  synchronous active-low reset                     |
// |               vga   master modport of t03_vga_timing_if                  |
// |                     (pixel_en, color_in in; counters, pulses, sync,      |
// |                      active, rgb_out out)                                |
// | Notes       : every porch/sync/active segment must be at least 1 wide.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module t03_vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               nrst,
  t03_vga_timing_if.master   vga
);

  localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each segment; the phase advances on the tick leaving it.
  localparam logic [10:0] c_h_act_end  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] c_h_fp_end   = 11'(H_ACTIVE + H_FRONT - 1);
  localparam logic [10:0] c_h_sync_end = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] c_h_last     = 11'(c_h_total - 1);
  localparam logic [10:0] c_v_act_end  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] c_v_fp_end   = 11'(V_ACTIVE + V_FRONT - 1);
  localparam logic [10:0] c_v_sync_end = 11'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] c_v_last     = 11'(c_v_total - 1);

  localparam logic [1:0] c_ph_active = 2'd0;
  localparam logic [1:0] c_ph_front  = 2'd1;
  localparam logic [1:0] c_ph_sync   = 2'd2;
  localparam logic [1:0] c_ph_back   = 2'd3;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [1:0]  h_phase_q, h_phase_d;
  logic [1:0]  v_phase_q, v_phase_d;
  logic        active_q, active_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_visible;

  assign w_h_wrap = (h_cnt_q == c_h_last);
  assign w_v_wrap = (v_cnt_q == c_v_last);

  // ---------------------------------------------------------------------
  // Phase FSMs: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      h_phase_q <= c_ph_active;
      v_phase_q <= c_ph_active;
    end else begin
      h_phase_q <= h_phase_d;
      v_phase_q <= v_phase_d;
    end
  end

  // ---------------------------------------------------------------------
  // Phase FSMs: next state. Transitions line up with the counter value
  // being left so the phase always matches the decode of the counter.
  // ---------------------------------------------------------------------
  always_comb begin
    h_phase_d = h_phase_q;
    if (vga.pixel_en) begin
      case (h_phase_q)
        c_ph_active: if (h_cnt_q == c_h_act_end)  h_phase_d = c_ph_front;
        c_ph_front:  if (h_cnt_q == c_h_fp_end)   h_phase_d = c_ph_sync;
        c_ph_sync:   if (h_cnt_q == c_h_sync_end) h_phase_d = c_ph_back;
        c_ph_back:   if (w_h_wrap)                h_phase_d = c_ph_active;
        default:                                  h_phase_d = c_ph_active;
      endcase
    end
  end

  // Vertical phase only moves on the line-wrap tick.
  always_comb begin
    v_phase_d = v_phase_q;
    if (vga.pixel_en && w_h_wrap) begin
      case (v_phase_q)
        c_ph_active: if (v_cnt_q == c_v_act_end)  v_phase_d = c_ph_front;
        c_ph_front:  if (v_cnt_q == c_v_fp_end)   v_phase_d = c_ph_sync;
        c_ph_sync:   if (v_cnt_q == c_v_sync_end) v_phase_d = c_ph_back;
        c_ph_back:   if (w_v_wrap)                v_phase_d = c_ph_active;
        default:                                  v_phase_d = c_ph_active;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Phase FSMs: outputs (one pixel_en tick of latency via the pin stage)
  // ---------------------------------------------------------------------
  always_comb begin
    w_visible = (h_phase_q == c_ph_active) && (v_phase_q == c_ph_active);
    active_d  = active_q;
    rgb_d     = rgb_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    if (vga.pixel_en) begin
      active_d = w_visible;
      // Blanking forces black so colour-mux garbage never reaches the pins.
      rgb_d    = w_visible ? vga.color_in : 8'h00;
      hsync_d  = (h_phase_q == c_ph_sync) ? SYNC_POL : ~SYNC_POL;
      vsync_d  = (v_phase_q == c_ph_sync) ? SYNC_POL : ~SYNC_POL;
    end
  end

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (vga.pixel_en) begin
      if (w_h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = w_v_wrap ? 11'd0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      active_q <= 1'b0;
      rgb_q    <= 8'h00;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      active_q <= active_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. The start pulses are decodes of the counters; they are held
  // low while in reset so the reset state shows no pulse.
  // ---------------------------------------------------------------------
  assign vga.Hcnt        = h_cnt_q;
  assign vga.Vcnt        = v_cnt_q;
  assign vga.line_start  = nrst && (h_cnt_q == 11'd0);
  assign vga.frame_start = nrst && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
  assign vga.active      = active_q;
  assign vga.rgb_out     = rgb_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_t03_vga_timing.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_t03_vga_timing                                          |
// | Description : Self-checking bench. DUT A uses the SVGA defaults,         |
// |               DUT B a tiny raster with active-low sync so whole frames   |
// |               fit in a short run. Expected pin outputs are pushed to a   |
// |               queue on each drive and popped after the clock edge.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_t03_vga_timing;

  localparam int AHA = 800, AHF = 40, AHS = 128, AHB = 88;
  localparam int AVA = 600, AVF = 1,  AVS = 4,   AVB = 23;
  localparam int BHA = 16,  BHF = 4,  BHS = 6,   BHB = 4;
  localparam int BVA = 8,   BVF = 1,  BVS = 2,   BVB = 3;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [7:0] rgb;
  } out_t;

  logic clk = 1'b0;
  logic nrst;

  t03_vga_timing_if if_a ();
  t03_vga_timing_if if_b ();

  always #5 clk = ~clk;

  // Colour source varies per line so line-to-line mistakes show up.
  function automatic logic [7:0] color_of(input logic [10:0] h, input logic [10:0] v);
    return h[7:0] ^ {v[3:0], 4'h0};
  endfunction

  assign if_a.color_in = color_of(if_a.Hcnt, if_a.Vcnt);
  assign if_b.color_in = color_of(if_b.Hcnt, if_b.Vcnt);

  t03_vga_timing u_dut_a (
    .clk  (clk),
    .nrst (nrst),
    .vga  (if_a.master)
  );

  t03_vga_timing #(
    .H_ACTIVE (BHA), .H_FRONT (BHF), .H_SYNC (BHS), .H_BACK (BHB),
    .V_ACTIVE (BVA), .V_FRONT (BVF), .V_SYNC (BVS), .V_BACK (BVB),
    .SYNC_POL (1'b0)
  ) u_dut_b (
    .clk  (clk),
    .nrst (nrst),
    .vga  (if_b.master)
  );

  int   checks = 0;
  int   errors = 0;
  out_t q_a[$];
  out_t q_b[$];
  int   mha = 0, mva = 0, mhb = 0, mvb = 0;
  out_t moa, mob;

  function automatic out_t pix_out(input int h, input int v,
                                   input int ha, input int hf, input int hsw,
                                   input int va, input int vf, input int vsw,
                                   input bit pol);
    out_t o;
    bit   in_hs, in_vs;
    in_hs = (h >= ha + hf) && (h < ha + hf + hsw);
    in_vs = (v >= va + vf) && (v < va + vf + vsw);
    o.hs  = in_hs ? pol : ~pol;
    o.vs  = in_vs ? pol : ~pol;
    o.act = (h < ha) && (v < va);
    o.rgb = o.act ? color_of(11'(h), 11'(v)) : 8'h00;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the reference model, push the expected
  // pin outputs, then pop and compare after the edge.
  task automatic step(input logic en, input logic rn);
    out_t ea, eb;
    if_a.pixel_en = en;
    if_b.pixel_en = en;
    nrst          = rn;
    if (!rn) begin
      mha = 0; mva = 0; mhb = 0; mvb = 0;
      moa = '{1'b0, 1'b0, 1'b0, 8'h00};
      mob = '{1'b1, 1'b1, 1'b0, 8'h00};
    end else if (en) begin
      moa = pix_out(mha, mva, AHA, AHF, AHS, AVA, AVF, AVS, 1'b1);
      mob = pix_out(mhb, mvb, BHA, BHF, BHS, BVA, BVF, BVS, 1'b0);
      if (mha == AHT - 1) begin
        mha = 0;
        mva = (mva == AVT - 1) ? 0 : mva + 1;
      end else begin
        mha = mha + 1;
      end
      if (mhb == BHT - 1) begin
        mhb = 0;
        mvb = (mvb == BVT - 1) ? 0 : mvb + 1;
      end else begin
        mhb = mhb + 1;
      end
    end
    q_a.push_back(moa);
    q_b.push_back(mob);
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    check("a_hcnt",   if_a.Hcnt, mha);
    check("a_vcnt",   if_a.Vcnt, mva);
    check("a_line",   if_a.line_start,  rn && (mha == 0));
    check("a_frame",  if_a.frame_start, rn && (mha == 0) && (mva == 0));
    check("a_hsync",  if_a.hsync,   ea.hs);
    check("a_vsync",  if_a.vsync,   ea.vs);
    check("a_active", if_a.active,  ea.act);
    check("a_rgb",    if_a.rgb_out, ea.rgb);
    check("b_hcnt",   if_b.Hcnt, mhb);
    check("b_vcnt",   if_b.Vcnt, mvb);
    check("b_line",   if_b.line_start,  rn && (mhb == 0));
    check("b_frame",  if_b.frame_start, rn && (mhb == 0) && (mvb == 0));
    check("b_hsync",  if_b.hsync,   eb.hs);
    check("b_vsync",  if_b.vsync,   eb.vs);
    check("b_active", if_b.active,  eb.act);
    check("b_rgb",    if_b.rgb_out, eb.rgb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no end of run, expected finish before 2 ms");
    $fatal(1, "timeout");
  end

  initial begin
    int hs_cnt, ls_cnt, first_hs, vs_low, hs_low, fs_cnt;
    if_a.pixel_en = 1'b0;
    if_b.pixel_en = 1'b0;
    nrst          = 1'b0;
    moa           = '{1'b0, 1'b0, 1'b0, 8'h00};
    mob           = '{1'b1, 1'b1, 1'b0, 8'h00};

    // Reset with pixel_en high: reset must win.
    repeat (3) step(1'b1, 1'b0);
    check("rst_hcnt",       if_a.Hcnt, 0);
    check("rst_vcnt",       if_a.Vcnt, 0);
    check("rst_line_start", if_a.line_start, 0);
    check("rst_hsync_a",    if_a.hsync, 0);
    check("rst_vsync_b",    if_b.vsync, 1);
    check("rst_rgb",        if_a.rgb_out, 0);

    // One full SVGA line.
    hs_cnt = 0; ls_cnt = 0; first_hs = -1;
    for (int i = 0; i < AHT; i++) begin
      step(1'b1, 1'b1);
      if (if_a.hsync === 1'b1) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(if_a.Hcnt);
      end
      if (if_a.line_start === 1'b1) ls_cnt++;
    end
    check("line_wrap_hcnt",   if_a.Hcnt, 0);
    check("line_wrap_vcnt",   if_a.Vcnt, 1);
    check("line_start_wrap",  if_a.line_start, 1);
    check("hsync_width",      hs_cnt, 128);
    check("hsync_first_hcnt", first_hs, 841);
    check("line_start_count", ls_cnt, 1);

    // Disabled ticks hold everything, including the line_start pulse.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("hold_hcnt",       if_a.Hcnt, 0);
    check("hold_line_start", if_a.line_start, 1);
    step(1'b1, 1'b1);
    check("resume_hcnt",       if_a.Hcnt, 1);
    check("resume_line_start", if_a.line_start, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
    end

    // Mid-frame reset at Hcnt=500.
    for (int i = 0; i < 2 * AHT && mha != 500; i++) step(1'b1, 1'b1);
    check("reach_hcnt_500", if_a.Hcnt, 500);
    repeat (3) step(1'b1, 1'b0);
    check("midrst_hcnt",   if_a.Hcnt, 0);
    check("midrst_vcnt",   if_a.Vcnt, 0);
    check("midrst_hsync",  if_a.hsync, 0);
    check("midrst_vsyncb", if_b.vsync, 1);
    check("midrst_active", if_a.active, 0);

    // One whole small frame on DUT B (active-low sync).
    vs_low = 0; hs_low = 0; fs_cnt = 0;
    for (int i = 0; i < BHT * BVT; i++) begin
      step(1'b1, 1'b1);
      if (i == 0) begin
        check("first_pix_active", if_a.active, 1);
        check("first_pix_rgb",    if_a.rgb_out, 0);
      end
      if (if_b.vsync === 1'b0) vs_low++;
      if (if_b.hsync === 1'b0) hs_low++;
      if (if_b.frame_start === 1'b1) fs_cnt++;
    end
    check("b_vsync_ticks",  vs_low, BVS * BHT);
    check("b_hsync_ticks",  hs_low, BHS * BVT);
    check("b_frame_starts", fs_cnt, 1);

    // Random enable soak; the scoreboard checks every cycle.
    for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 3) != 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
